// File: rtl/rr_arb8_if.sv
// rr_arb8_if
// Request/grant bundle for the eight-way round-robin arbiter.
//   en       - arbitration enable (from requesting side)
//   req[7:0] - request lines, bit i belongs to requester i
//   gnt[7:0] - registered one-hot grant
//   gnt_idx  - binary index of the granted requester, 0 when idle
//   gnt_vld  - high exactly when gnt is nonzero
//   timeout  - one-cycle pulse when the watchdog revokes a grant
// master: the requesting side. slave: the arbiter.
interface rr_arb8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8
// Round-robin arbiter for eight requesters sharing one resource. A grant is
// issued from IDLE to the first requester found searching upward from the
// rotating pointer, then held until the owner drops its request or en goes
// low. Every release passes through one IDLE cycle, so grants never abut.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - rr_arb8_if.slave (en, req in; gnt, gnt_idx, gnt_vld, timeout out)
//
// Parameter:
//   TIMEOUT - maximum consecutive grant cycles per owner (2..255), only
//             meaningful when the watchdog is built.
//
// Build option:
//   ARB_TIMEOUT_EN - when defined, a hold counter revokes a grant after
//                    TIMEOUT cycles and pulses timeout; when undefined no
//                    counter exists and timeout is tied low.
module rr_arb8 #(
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       rst_n,
  rr_arb8_if.slave  bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arb8: TIMEOUT must be within 2..255");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] gnt_q;
  logic [7:0] gnt_nxt;
  logic [2:0] idx_q;
  logic [2:0] idx_nxt;
  logic       vld_q;
  logic       vld_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] pick;
  logic       found;
  logic       hold_expired;

  // First requester at or above ptr, wrapping 7 -> 0. The 3-bit sum wraps
  // naturally, so the loop walks ptr, ptr+1, ... ptr+7 modulo 8.
  always_comb begin
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && bus.req[ptr + 3'(i)]) begin
        pick  = ptr + 3'(i);
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] hold_cnt;
  logic       timeout_q;
  logic       watchdog_fire;

  // Counter reads 0 in the first grant cycle, so reaching TIMEOUT-1 means
  // the grant has been visible for TIMEOUT cycles at the coming edge.
  assign hold_expired  = (state == GRANT) && (hold_cnt == HOLD_LAST);

  // The pulse is only a watchdog event when the owner would otherwise
  // have kept the grant; a normal release on the same edge wins.
  assign watchdog_fire = hold_expired && bus.en && bus.req[idx_q];

  // Hold counter runs only while a grant persists and restarts on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= watchdog_fire;
      if (state == GRANT && state_nxt == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        hold_cnt <= 8'd0;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  // Next-state and next-output logic. Release clears all grant outputs
  // together and advances the pointer past the previous owner.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx_q;
    vld_nxt   = vld_q;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        gnt_nxt = 8'h00;
        idx_nxt = 3'd0;
        vld_nxt = 1'b0;
        if (bus.en && found) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'(1) << pick;
          idx_nxt   = pick;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.en || !bus.req[idx_q] || hold_expired) begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          idx_nxt   = 3'd0;
          vld_nxt   = 1'b0;
          ptr_nxt   = idx_q + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 8'h00;
        idx_nxt   = 3'd0;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      gnt_q <= 8'h00;
      idx_q <= 3'd0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      vld_q <= vld_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8
// Scoreboard bench for rr_arb8. The driver applies inputs on the falling
// edge, advances a behavioural model (owner / pointer / hold count as plain
// integers) and queues the outputs expected after the next rising edge.
// A monitor samples the DUT 1 time unit after each rising edge and compares
// against the head of the queue. Directed phases follow the arbiter's
// reset, rotation, wrap, enable, async reset and long-hold scenarios, then
// a randomized phase runs against the same model.
module tb_rr_arb8;

  localparam int TIMEOUT_CYC = 4;

  logic clk = 1'b0;
  logic rst_n;

  rr_arb8_if bus();

  rr_arb8 #(.TIMEOUT(TIMEOUT_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       timeout;
  } resp_t;

  resp_t exp_q[$];
  int    grant_log[$];
  int    exp_log[$];
  int    num_vectors     = 0;
  int    num_miscompares = 0;
  bit    monitor_on      = 1'b0;
  bit    prev_vld        = 1'b0;
  resp_t mon_act;
  resp_t mon_exp;

  // Model state: current owner (-1 when idle), search pointer, cycles held.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_held    = 0;
  bit m_timeout = 1'b0;

  task automatic checkOutput(input string name, input resp_t act, input resp_t exp);
    num_vectors++;
    if (act !== exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s @%0t: got gnt=%02h idx=%0d vld=%0b timeout=%0b, expected gnt=%02h idx=%0d vld=%0b timeout=%0b",
               name, $time, act.gnt, act.idx, act.vld, act.timeout,
               exp.gnt, exp.idx, exp.vld, exp.timeout);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    num_vectors++;
    if (act != exp) begin
      num_miscompares++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic checkLog(input string name);
    string act_s;
    string exp_s;
    bit    bad;
    act_s = "";
    exp_s = "";
    bad   = (grant_log.size() != exp_log.size());
    foreach (grant_log[i]) act_s = {act_s, $sformatf("%0d ", grant_log[i])};
    foreach (exp_log[i]) begin
      exp_s = {exp_s, $sformatf("%0d ", exp_log[i])};
      if (i < grant_log.size() && grant_log[i] != exp_log[i]) bad = 1'b1;
    end
    num_vectors++;
    if (bad) begin
      num_miscompares++;
      $display("[TB] FAIL %s: grant order got [ %s] expected [ %s]", name, act_s, exp_s);
    end
    grant_log.delete();
    exp_log.delete();
  endtask

  // Reference behaviour: owner keeps the resource while enabled and
  // requesting; an idle arbiter takes the first requester at or after the
  // pointer in circular order; a release moves the pointer past the owner.
  task automatic modelStep(input logic rstv, input logic e, input logic [7:0] r);
    m_timeout = 1'b0;
    if (!rstv) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (m_owner < 0 && r[3'(c)]) begin
            m_owner = c;
            m_held  = 1;
          end
        end
      end
    end else if (!e || !r[3'(m_owner)]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_held  = 0;
`ifdef ARB_TIMEOUT_EN
    end else if (m_held == TIMEOUT_CYC) begin
      m_ptr     = (m_owner + 1) % 8;
      m_owner   = -1;
      m_held    = 0;
      m_timeout = 1'b1;
`endif
    end else begin
      m_held++;
    end
  endtask

  function automatic resp_t modelResp();
    resp_t rsp;
    rsp = '0;
    if (m_owner >= 0) begin
      rsp.gnt = 8'(1) << m_owner;
      rsp.idx = 3'(m_owner);
      rsp.vld = 1'b1;
    end
    rsp.timeout = m_timeout;
    return rsp;
  endfunction

  task automatic applyStimulus(input logic rstv, input logic e, input logic [7:0] r);
    @(negedge clk);
    rst_n   = rstv;
    bus.en  = e;
    bus.req = r;
    modelStep(rstv, e, r);
    exp_q.push_back(modelResp());
    monitor_on = 1'b1;
  endtask

  task automatic repeatStimulus(input int n, input logic e, input logic [7:0] r);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, e, r);
  endtask

  // Monitor: one popped expectation per rising edge once the driver starts.
  always @(posedge clk) begin
    if (monitor_on) begin
      #1;
      mon_act = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout};
      if (exp_q.size() == 0) begin
        num_vectors++;
        num_miscompares++;
        $display("[TB] FAIL scoreboard_underflow @%0t: got output with no expectation queued", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("cycle", mon_act, mon_exp);
      end
      if (mon_act.vld && !prev_vld) grant_log.push_back(int'(mon_act.idx));
      prev_vld = mon_act.vld;
    end
  end

  task automatic printSummary();
    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
  endtask

  initial begin
    #1_000_000;
    num_miscompares++;
    $display("[TB] FAIL global_time_limit: got still running at %0t, expected finish", $time);
    printSummary();
    $finish;
  end

  initial begin
    logic [7:0] r;
    logic       e;
    logic       rv;

    // Reset held with every requester active: outputs must stay clear.
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'hFF;
    #1;
    checkOutput("reset_outputs", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, '0);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b0, 1'b1, 8'hFF);

    // Rotation: all request, each owner drops for one cycle after 2 cycles.
    for (int cyc = 0; cyc < 60 && grant_log.size() < 9; cyc++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_held >= 2) r[3'(m_owner)] = 1'b0;
      applyStimulus(1'b1, 1'b1, r);
    end
    repeatStimulus(3, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) exp_log.push_back(i % 8);
    checkLog("rotation_order");

    // Wrap: park pointer at 6 via requester 5, then 0 and 5 compete.
    repeatStimulus(2, 1'b1, 8'h20);
    repeatStimulus(1, 1'b1, 8'h00);
    repeatStimulus(2, 1'b1, 8'h21);
    repeatStimulus(3, 1'b1, 8'h20);
    repeatStimulus(3, 1'b1, 8'h00);
    exp_log.push_back(5);
    exp_log.push_back(0);
    exp_log.push_back(5);
    checkLog("wrap_order");

    // Enable: revoke requester 3, stay blocked, then resume from 4.
    repeatStimulus(2, 1'b1, 8'h08);
    repeatStimulus(1, 1'b0, 8'h08);
    repeatStimulus(10, 1'b0, 8'hFF);
    repeatStimulus(1, 1'b1, 8'hFF);
    repeatStimulus(3, 1'b1, 8'h00);
    exp_log.push_back(3);
    exp_log.push_back(4);
    checkLog("enable_order");

    // Async reset in the middle of a grant to requester 5.
    repeatStimulus(2, 1'b1, 8'h20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_clear", {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout}, '0);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    repeatStimulus(3, 1'b1, 8'h00);
    exp_log.push_back(5);
    exp_log.push_back(0);
    checkLog("async_reset_order");

    // Long hold by requester 2, then requester 3 joins.
    repeatStimulus(110, 1'b1, 8'h04);
    repeatStimulus(6, 1'b1, 8'h0C);
    repeatStimulus(3, 1'b1, 8'h00);
`ifdef ARB_TIMEOUT_EN
    checkValue("long_hold_first_owner", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    grant_log.delete();
`else
    exp_log.push_back(2);
    checkLog("long_hold_order");
`endif

    // Randomized traffic with occasional resets and enable drops.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rv = ($urandom_range(0, 99) != 0);
      e  = ($urandom_range(0, 9) != 0);
      r  = 8'($urandom);
      if (m_owner >= 0) r[3'(m_owner)] = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, e, r);
    end

    @(posedge clk);
    #3;
    monitor_on = 1'b0;
    checkValue("scoreboard_drained", exp_q.size(), 0);
    printSummary();
    $finish;
  end

endmodule
